// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse-round datapath: GF(2^8) arithmetic,
// forward/inverse S-box, round constants, InvShiftRows/InvSubBytes and the
// inverse key-schedule step. The S-boxes are computed from the field inverse and
// the affine map, not stored as tables. The key step is only instantiated when
// AES_INV_KEYGEN_EN is defined.
package aes_pkg;

  localparam int NB = 4;
  localparam logic [7:0] GF_POLY = 8'h1b;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add over the bits of b.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] cur;
    acc = 8'h00;
    cur = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (b[i] ? cur : 8'h00);
      cur = gf_xtime(cur);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] pw;
    logic [7:0] acc;
    pw  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      acc = gf_mul(acc, pw);
    end
    return acc;
  endfunction

  // Rotate a byte left by n bit positions (n in 0..7).
  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] dbl;
    dbl = {x, x};
    return dbl[15-n -: 8];
  endfunction

  // Forward S-box: field inverse followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  // Inverse S-box: inverse affine transform followed by the field inverse.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
    return gf_inv(b);
  endfunction

  // Round constant for round r (1..10); zero outside that range.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Row r of the column-major state is rotated right by r byte positions.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] res;
    res = 128'h0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return res;
  endfunction

  // Inverse S-box applied to all 16 bytes.
  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] res;
    res = 128'h0;
    for (int i = 0; i < 16; i++) begin
      res[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    end
    return res;
  endfunction

  // Recover K(r-1) from K(r): undo the forward schedule's XOR chain, then the g() word.
  function automatic logic [127:0] inv_key_step(input logic [127:0] key, input logic [3:0] r);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] rot, sub;
    w0  = key[127:96];
    w1  = key[95:64];
    w2  = key[63:32];
    w3  = key[31:0];
    p3  = w3 ^ w2;
    p2  = w2 ^ w1;
    p1  = w1 ^ w0;
    rot = {p3[23:0], p3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    p0  = w0 ^ sub ^ {rcon(r), 24'h000000};
    return {p0, p1, p2, p3};
  endfunction

endpackage

// File: rtl/aes_inv_mix_columns.sv
// Combinational InvMixColumns over the four 32-bit columns of a 128-bit state
// (byte 0 in [127:120], column-major).
module aes_inv_mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] state,
  output logic [127:0] mixed
);

  // One column times the fixed matrix {0e 0b 0d 09} (circulant).
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    b1 = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    b2 = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    b3 = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    return {b0, b1, b2, b3};
  endfunction

  // Columns are independent, so mix each one in turn.
  always_comb begin
    mixed = 128'h0;
    for (int c = 0; c < NB; c++) begin
      mixed[127-32*c -: 32] = inv_mix_col(state[127-32*c -: 32]);
    end
  end

endmodule

// File: rtl/aes_inv_round.sv
// One AES-128 inverse-cipher round as a two-stage valid/ready pipeline.
// Stage 1 registers InvSubBytes(InvShiftRows(state_in)) with the round key and
// tags; stage 2 adds the key and applies InvMixColumns unless last_round is set.
// Optional feature macro: AES_INV_KEYGEN_EN -- when defined, K(r-1) is derived
// from K(r) in stage 1 and presented on prev_round_key alongside state_out;
// otherwise prev_round_key is constant zero and no key-step logic exists.
module aes_inv_round
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic [3:0]   round_idx,
  input  logic         last_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic [127:0] prev_round_key,
  output logic [3:0]   round_idx_out
);

  if (Nk != 4 || Nr < 1 || Nr > 15) begin : g_bad_cfg
    $error("aes_inv_round: only Nk=4 with Nr in 1..15 is supported");
  end

  logic         s1_valid_r;
  logic [127:0] s1_state_r;
  logic [127:0] s1_key_r;
  logic [3:0]   s1_idx_r;
  logic         s1_last_r;

  logic         s2_valid_r;
  logic [127:0] s2_state_r;
  logic [3:0]   s2_idx_r;

  logic         s2_ready_s;
  logic [127:0] t1_s;
  logic [127:0] u_s;
  logic [127:0] mixed_s;
  logic [127:0] s2_next_s;

  // Ready ripples back combinationally so a full pipe still moves every cycle.
  assign s2_ready_s = ~s2_valid_r | out_ready;
  assign in_ready   = ~s1_valid_r | s2_ready_s;

  assign t1_s = inv_sub_bytes(inv_shift_rows(state_in));
  assign u_s  = s1_state_r ^ s1_key_r;

  aes_inv_mix_columns u_mix (
    .state (u_s),
    .mixed (mixed_s)
  );

  // Final round skips InvMixColumns.
  always_comb begin
    if (s1_last_r) begin
      s2_next_s = u_s;
    end else begin
      s2_next_s = mixed_s;
    end
  end

  // Stage-1 occupancy: refills (or empties) whenever it can accept, else holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_r <= 1'b0;
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
    end
  end

  // Stage-1 data captured only on an accepted input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_state_r <= 128'h0;
      s1_key_r   <= 128'h0;
      s1_idx_r   <= 4'h0;
      s1_last_r  <= 1'b0;
    end else if (in_valid && in_ready) begin
      s1_state_r <= t1_s;
      s1_key_r   <= round_key;
      s1_idx_r   <= round_idx;
      s1_last_r  <= last_round;
    end
  end

  // Stage-2 occupancy: takes stage 1's valid whenever the output slot frees up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_r <= 1'b0;
    end else if (s2_ready_s) begin
      s2_valid_r <= s1_valid_r;
    end
  end

  // Stage-2 data only changes on a stage-1 to stage-2 transfer, so stalls hold it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_state_r <= 128'h0;
      s2_idx_r   <= 4'h0;
    end else if (s1_valid_r && s2_ready_s) begin
      s2_state_r <= s2_next_s;
      s2_idx_r   <= s1_idx_r;
    end
  end

  assign out_valid     = s2_valid_r;
  assign state_out     = s2_state_r;
  assign round_idx_out = s2_idx_r;

`ifdef AES_INV_KEYGEN_EN
  localparam logic [3:0] NR_IDX = 4'(Nr);

  logic [127:0] pk_next_s;
  logic [127:0] s1_pk_r;
  logic [127:0] s2_pk_r;

  // Key step is defined only for rounds 1..Nr; other indices yield zero.
  always_comb begin
    if ((round_idx != 4'd0) && (round_idx <= NR_IDX)) begin
      pk_next_s = inv_key_step(round_key, round_idx);
    end else begin
      pk_next_s = 128'h0;
    end
  end

  // Previous key travels with its data through stage 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_pk_r <= 128'h0;
    end else if (in_valid && in_ready) begin
      s1_pk_r <= pk_next_s;
    end
  end

  // Previous key travels with its data through stage 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_pk_r <= 128'h0;
    end else if (s1_valid_r && s2_ready_s) begin
      s2_pk_r <= s1_pk_r;
    end
  end

  assign prev_round_key = s2_pk_r;
`else
  assign prev_round_key = 128'h0;
`endif

endmodule
